pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Controller that sequences the fetch-stage program counter register of the 5-stage MIPS150 pipeline. Each cycle it selects the next-PC source, gates PC updates during boot and stalls, holds a redirect that arrives while memory is busy, and drives a multi-cycle squash window after every control transfer. It sits between the hazard/decode/branch logic and the PC register, which it drives through `PC_Sel`/`PC_EN`.

## Interface
- `BOOT_CYCLES`, default 2: cycles `PC_EN` stays low after reset release (IMEM warm-up); legal range 1..15.
- `FLUSH_CYCLES`, default 2: cycles `Flush_IF` stays high after an accepted redirect; legal range 1..3.
- `CLK`  in  1  clock; all state updates on posedge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `Mem_Busy`  in  1  multi-cycle memory stall; freezes the whole front end.
- `Stall_Load`  in  1  load-use hazard; holds PC for this cycle.
- `Branch_Taken`  in  1  EX-stage branch resolved taken.
- `Is_JR`  in  1  ID-stage JR/JALR decoded.
- `Is_JAL`  in  1  ID-stage J/JAL decoded.
- `PC_Sel`  out  2  next-PC source: 00 PC+4, 01 branch, 10 JR, 11 JAL.
- `PC_EN`  out  1  PC register load enable.
- `Flush_IF`  out  1  squash the IF/ID register.
- `Bubble_EX`  out  1  insert a NOP into ID/EX (load-use or branch squash).
- `Redirect_Pending`  out  1  a redirect is latched and waiting on `Mem_Busy`.

## Operation
- States: BOOT, RUN, HOLD, FLUSH.
- Reset (async, `RST_N`=0): state BOOT; boot counter = `BOOT_CYCLES`; flush counter = 0; pending register empty. Outputs: `PC_EN`=0, `PC_Sel`=00, `Flush_IF`=0, `Bubble_EX`=0, `Redirect_Pending`=0.
- BOOT: `PC_EN`=0. Counter decrements each cycle and goes to RUN when it reaches 1. All other inputs are ignored.
- Redirect request priority, highest first: `Branch_Taken` (01), `Is_JR` (10), `Is_JAL` (11). Simultaneous requests resolve to the highest priority; `Branch_Taken` wins because the EX instruction is older.
- RUN:
  - `Mem_Busy`=1: `PC_EN`=0. Any redirect request is latched into the pending register (sel + valid). Go to HOLD.
  - Else, redirect request present: `PC_EN`=1, `PC_Sel`=winner. Flush counter loads `FLUSH_CYCLES`. Go to FLUSH. `Bubble_EX`=1 this cycle only if `Branch_Taken` is the winner.
  - Else `Stall_Load`: `PC_EN`=0, `PC_Sel`=00, `Bubble_EX`=1.
  - Else: `PC_EN`=1, `PC_Sel`=00.
- HOLD: `PC_EN`=0 while `Mem_Busy`=1.
  - A new request overwrites the pending register only if its priority is strictly higher.
  - On the cycle `Mem_Busy`=0: if pending is valid, issue it exactly as in RUN (go to FLUSH, clear pending). Otherwise behave as RUN for that cycle.
- FLUSH:
  - `Flush_IF`=1 and `PC_EN`=1 with `PC_Sel`=00, so fetch continues down the new path.
  - Redirect inputs are ignored; they come from squashed instructions.
  - Counter decrements per cycle. At 1, go to RUN.
  - `Mem_Busy` in FLUSH: `PC_EN`=0, the counter freezes, `Flush_IF` stays 1.
- `Redirect_Pending` = pending valid bit (registered).

## Timing
- `PC_Sel` and `PC_EN` are combinational from state and inputs (Mealy), so the PC register loads the redirect target on the same edge the request is seen. There is zero added redirect latency.
- `Flush_IF` is registered. It goes high the cycle after redirect acceptance and stays high exactly `FLUSH_CYCLES` non-busy cycles.
- `Bubble_EX` is combinational, valid in the same cycle as the condition.
- Boot: the first `PC_EN`=1 occurs in cycle `BOOT_CYCLES`+1 after `RST_N` rises (cycle 1 = first posedge with `RST_N`=1).
- Reset asserted mid-FLUSH or mid-HOLD returns immediately to reset values and discards any pending redirect.
- Counters are 4 bits (boot) and 2 bits (flush). Decrement never wraps; a counter at 0 stays 0.

## Test plan
- Reset release, `BOOT_CYCLES`=2, no inputs -> `PC_EN` low for cycles 1–2, high from cycle 3, `PC_Sel`=00 throughout.
- In RUN, `Branch_Taken`=1 and `Is_JAL`=1 in the same cycle -> `PC_Sel`=01, `PC_EN`=1, `Bubble_EX`=1 that cycle; `Flush_IF`=1 for the next 2 cycles; an `Is_JR` pulse during those cycles is ignored.
- `Stall_Load`=1 for 1 cycle in RUN -> `PC_EN`=0 and `Bubble_EX`=1 for that cycle only; next cycle `PC_EN`=1, `PC_Sel`=00.
- `Mem_Busy`=1 for 3 cycles with `Is_JAL` in cycle 1 and `Branch_Taken` in cycle 2 -> `Redirect_Pending`=1 from cycle 2; on the first non-busy cycle `PC_Sel`=01 (branch overwrote JAL), `PC_EN`=1, then pending clears.
- `Mem_Busy` asserted during FLUSH for 2 cycles -> `PC_EN`=0 and `Flush_IF` held at 1; total `Flush_IF` cycles = 2 + 2 busy cycles.
- `RST_N` dropped asynchronously mid-HOLD with a pending JR -> all outputs reach reset values before the next edge; after release, no JR redirect is ever issued.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC source selection and PC-update gating for the fetch
// stage of a 5-stage MIPS pipeline. It holds the PC during IMEM warm-up and
// stalls, parks a redirect that arrives while memory is busy, and squashes
// IF/ID for a fixed window after every accepted control transfer.
module pc_sequencer #(
   parameter int BOOT_CYCLES  = 2,  // 1..15: PC_EN held low after reset release
   parameter int FLUSH_CYCLES = 2   // 1..3 : Flush_IF window after a redirect
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       Mem_Busy,
   input  logic       Stall_Load,
   input  logic       Branch_Taken,
   input  logic       Is_JR,
   input  logic       Is_JAL,
   output logic [1:0] PC_Sel,
   output logic       PC_EN,
   output logic       Flush_IF,
   output logic       Bubble_EX,
   output logic       Redirect_Pending
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SEL_PC4 = 2'b00,
      SEL_BR  = 2'b01,
      SEL_JR  = 2'b10,
      SEL_JAL = 2'b11
   } pc_sel_e;

   localparam logic [3:0] BOOT_INIT  = 4'(BOOT_CYCLES);
   localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

   // Redirect priority: the branch in EX is older than the jump in ID, so it
   // wins; JR outranks J/JAL. An empty slot ranks lowest.
   function automatic logic [1:0] sel_rank(input logic valid, input pc_sel_e sel);
      logic [1:0] rank;
      rank = 2'd0;
      if (valid) begin
         case (sel)
            SEL_BR:  rank = 2'd3;
            SEL_JR:  rank = 2'd2;
            SEL_JAL: rank = 2'd1;
            default: rank = 2'd0;
         endcase
      end
      return rank;
   endfunction

   state_e     state_q,      state_d;
   logic [3:0] boot_cnt_q,   boot_cnt_d;
   logic [1:0] flush_cnt_q,  flush_cnt_d;
   logic       pend_valid_q, pend_valid_d;
   pc_sel_e    pend_sel_q,   pend_sel_d;
   logic       flush_if_q,   flush_if_d;

   logic       req_valid;
   pc_sel_e    req_sel;
   logic       run_like;
   pc_sel_e    pc_sel;

   // Resolve simultaneous redirect requests to the single winner.
   always_comb begin
      req_valid = Branch_Taken | Is_JR | Is_JAL;
      if (Branch_Taken)  req_sel = SEL_BR;
      else if (Is_JR)    req_sel = SEL_JR;
      else if (Is_JAL)   req_sel = SEL_JAL;
      else               req_sel = SEL_PC4;
   end

   // Next-state, counter and Mealy output logic.
   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (which would infer a latch).
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      pend_valid_d = pend_valid_q;
      pend_sel_d   = pend_sel_q;
      pc_sel       = SEL_PC4;
      PC_EN        = 1'b0;
      Bubble_EX    = 1'b0;
      run_like     = 1'b0;

      case (state_q)
         ST_BOOT: begin
            // IMEM warm-up: every input is ignored until the count runs down.
            if (boot_cnt_q <= 4'd1) state_d = ST_RUN;
            if (boot_cnt_q != 4'd0) boot_cnt_d = boot_cnt_q - 4'd1;
         end

         ST_RUN: run_like = 1'b1;

         ST_HOLD: begin
            if (Mem_Busy) begin
               // Keep only the strongest redirect seen while frozen.
               if (req_valid &&
                   (sel_rank(1'b1, req_sel) > sel_rank(pend_valid_q, pend_sel_q))) begin
                  pend_valid_d = 1'b1;
                  pend_sel_d   = req_sel;
               end
            end else if (pend_valid_q) begin
               PC_EN        = 1'b1;
               pc_sel       = pend_sel_q;
               Bubble_EX    = (pend_sel_q == SEL_BR);
               flush_cnt_d  = FLUSH_INIT;
               pend_valid_d = 1'b0;
               pend_sel_d   = SEL_PC4;
               state_d      = ST_FLUSH;
            end else begin
               run_like = 1'b1;
            end
         end

         ST_FLUSH: begin
            // Fetch continues sequentially down the new path; redirect inputs
            // here come from squashed instructions and are dropped.
            if (!Mem_Busy) begin
               PC_EN = 1'b1;
               if (flush_cnt_q <= 2'd1) state_d = ST_RUN;
               if (flush_cnt_q != 2'd0) flush_cnt_d = flush_cnt_q - 2'd1;
            end
         end

         default: state_d = ST_BOOT;
      endcase

      // Normal fetch behaviour, shared by RUN and an idle HOLD release.
      if (run_like) begin
         state_d = ST_RUN;
         if (Mem_Busy) begin
            if (req_valid &&
                (sel_rank(1'b1, req_sel) > sel_rank(pend_valid_q, pend_sel_q))) begin
               pend_valid_d = 1'b1;
               pend_sel_d   = req_sel;
            end
            state_d = ST_HOLD;
         end else if (req_valid) begin
            PC_EN       = 1'b1;
            pc_sel      = req_sel;
            Bubble_EX   = (req_sel == SEL_BR);
            flush_cnt_d = FLUSH_INIT;
            state_d     = ST_FLUSH;
         end else if (Stall_Load) begin
            Bubble_EX = 1'b1;
         end else begin
            PC_EN = 1'b1;
         end
      end

      // Squash window is a registered decode of the state being entered.
      flush_if_d = (state_d == ST_FLUSH);
   end

   // State, counters, pending redirect and Flush_IF registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_BOOT;
         boot_cnt_q   <= BOOT_INIT;
         flush_cnt_q  <= 2'd0;
         pend_valid_q <= 1'b0;
         pend_sel_q   <= SEL_PC4;
         flush_if_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_sel_q   <= pend_sel_d;
         flush_if_q   <= flush_if_d;
      end
   end

   assign PC_Sel           = pc_sel;
   assign Flush_IF         = flush_if_q;
   assign Redirect_Pending = pend_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with the default parameters
// (BOOT_CYCLES=2, FLUSH_CYCLES=2). Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 units later, well before the next edge.
module tb_pc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       mem_busy;
   logic       stall_load;
   logic       branch_taken;
   logic       is_jr;
   logic       is_jal;
   logic [1:0] pc_sel;
   logic       pc_en;
   logic       flush_if;
   logic       bubble_ex;
   logic       redirect_pending;

   int n_checks = 0;
   int n_errors = 0;

   pc_sequencer #(
      .BOOT_CYCLES  (2),
      .FLUSH_CYCLES (2)
   ) dut (
      .CLK              (clk),
      .RST_N            (rst_n),
      .Mem_Busy         (mem_busy),
      .Stall_Load       (stall_load),
      .Branch_Taken     (branch_taken),
      .Is_JR            (is_jr),
      .Is_JAL           (is_jal),
      .PC_Sel           (pc_sel),
      .PC_EN            (pc_en),
      .Flush_IF         (flush_if),
      .Bubble_EX        (bubble_ex),
      .Redirect_Pending (redirect_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic en, input logic [1:0] sel,
                             input logic fl, input logic bub, input logic pend);
      check({tag, ".PC_EN"},            {1'b0, pc_en},            {1'b0, en});
      check({tag, ".PC_Sel"},           pc_sel,                   sel);
      check({tag, ".Flush_IF"},         {1'b0, flush_if},         {1'b0, fl});
      check({tag, ".Bubble_EX"},        {1'b0, bubble_ex},        {1'b0, bub});
      check({tag, ".Redirect_Pending"}, {1'b0, redirect_pending}, {1'b0, pend});
   endtask

   // Apply one cycle's inputs and let the combinational outputs settle.
   task automatic drive(input logic busy, input logic stall, input logic br,
                        input logic jr, input logic jal);
      mem_busy     = busy;
      stall_load   = stall;
      branch_taken = br;
      is_jr        = jr;
      is_jal       = jal;
      #2;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      mem_busy = 1'b0; stall_load = 1'b0; branch_taken = 1'b0; is_jr = 1'b0; is_jal = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      expect_out("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

      // Boot: PC_EN low in cycles 1-2 (a branch in cycle 2 is ignored), high from 3.
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0); expect_out("boot_c1", 0, 2'b00, 0, 0, 0); next_cycle();
      drive(0, 0, 1, 0, 0); expect_out("boot_c2", 0, 2'b00, 0, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("boot_c3", 1, 2'b00, 0, 0, 0); next_cycle();

      // Branch + JAL together: branch wins, bubble, then 2 flush cycles ignoring JR.
      drive(0, 0, 1, 0, 1); expect_out("br_jal",   1, 2'b01, 0, 1, 0); next_cycle();
      drive(0, 0, 0, 1, 0); expect_out("br_fl1",   1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 1, 0); expect_out("br_fl2",   1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("br_done",  1, 2'b00, 0, 0, 0); next_cycle();

      // JR + JAL together: JR wins, no bubble.
      drive(0, 0, 0, 1, 1); expect_out("jr_jal",   1, 2'b10, 0, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("jr_fl1",   1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("jr_fl2",   1, 2'b00, 1, 0, 0); next_cycle();

      // JAL alone, then Mem_Busy for 2 cycles in the last flush cycle: 4 flush cycles total.
      drive(0, 0, 0, 0, 1); expect_out("jal",      1, 2'b11, 0, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("jal_fl1",  1, 2'b00, 1, 0, 0); next_cycle();
      drive(1, 0, 0, 0, 0); expect_out("jal_fb1",  0, 2'b00, 1, 0, 0); next_cycle();
      drive(1, 0, 0, 0, 0); expect_out("jal_fb2",  0, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("jal_fl2",  1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("jal_done", 1, 2'b00, 0, 0, 0); next_cycle();

      // Load-use stall for one cycle.
      drive(0, 1, 0, 0, 0); expect_out("stall",    0, 2'b00, 0, 1, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("stall_nx", 1, 2'b00, 0, 0, 0); next_cycle();

      // Mem_Busy 3 cycles: JAL latched, branch overwrites, later JAL does not.
      drive(1, 0, 0, 0, 1); expect_out("busy_c1",  0, 2'b00, 0, 0, 0); next_cycle();
      drive(1, 0, 1, 0, 0); expect_out("busy_c2",  0, 2'b00, 0, 0, 1); next_cycle();
      drive(1, 0, 0, 0, 1); expect_out("busy_c3",  0, 2'b00, 0, 0, 1); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("busy_rel", 1, 2'b01, 0, 1, 1); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("busy_fl1", 1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("busy_fl2", 1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("busy_run", 1, 2'b00, 0, 0, 0); next_cycle();

      // Busy with nothing pending: release cycle behaves as RUN (JR accepted).
      drive(1, 0, 0, 0, 0); expect_out("hold_c1",  0, 2'b00, 0, 0, 0); next_cycle();
      drive(0, 0, 0, 1, 0); expect_out("hold_jr",  1, 2'b10, 0, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("hold_fl1", 1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("hold_fl2", 1, 2'b00, 1, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("hold_run", 1, 2'b00, 0, 0, 0); next_cycle();

      // Async reset mid-HOLD with a pending JR discards it.
      drive(1, 0, 0, 1, 0); expect_out("rst_c1",   0, 2'b00, 0, 0, 0); next_cycle();
      drive(1, 0, 0, 0, 0); expect_out("rst_c2",   0, 2'b00, 0, 0, 1);
      mem_busy = 1'b0;
      rst_n    = 1'b0;
      #1;
      expect_out("rst_async", 0, 2'b00, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0); expect_out("reboot_c1", 0, 2'b00, 0, 0, 0); next_cycle();
      drive(0, 0, 0, 0, 0); expect_out("reboot_c2", 0, 2'b00, 0, 0, 0); next_cycle();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0);
         expect_out($sformatf("reboot_run%0d", i), 1, 2'b00, 0, 0, 0);
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
